// File: rtl/sample_store_pkg.sv
// Shared types and defaults for apb_sample_store.
// Optional min/max tracking is enabled by SAMPLE_STORE_MINMAX_EN.
package sample_store_pkg;

   localparam int DATA_W    = 32;
   localparam int DEPTH_DEF = 128;
   localparam int WAIT_DEF  = 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sample_store_ram.sv
// Sample memory: one synchronous write port, a combinational APB
// read port and a registered, read-before-write side read port.
module sample_store_ram
   import sample_store_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = addr_w(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [AW-1:0]     i_raddr,
   output logic [DATA_W-1:0] o_rdata,
   input  logic              i_rd_en,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)     r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rdata   = r_mem[i_raddr];
   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/apb_sample_store.sv
// APB3 sample store slave with side read port and occupancy status.
// Define SAMPLE_STORE_MINMAX_EN to track min/max of committed samples.
module apb_sample_store
   import sample_store_pkg::*;
#(
   parameter  int DEPTH       = DEPTH_DEF,
   parameter  int WAIT_STATES = WAIT_DEF,
   parameter  int CNT_W       = 8,
   localparam int AW          = addr_w(DEPTH)
) (
   input  logic              pclk_i,
   input  logic              presetn_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic [7:0]        paddr_i,
   input  logic              pwrite_i,
   input  logic [DATA_W-1:0] pwdata_i,
   output logic [DATA_W-1:0] prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   input  logic              clr_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic              rd_hit_o,
   output logic [CNT_W-1:0]  wr_count_o,
   output logic              ovw_o,
   output logic [DATA_W-1:0] min_o,
   output logic [DATA_W-1:0] max_o
);

   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   state_t            r_state;
   logic [3:0]        r_wait;
   logic [AW-1:0]     r_addr;
   logic              r_write;
   logic              r_err;
   logic [DATA_W-1:0] r_wdata;
   logic              r_pready;
   logic              r_pslverr;
   logic [DEPTH-1:0]  r_valid;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovw;
   logic              r_rd_valid;
   logic              r_rd_hit;
   logic              w_commit;
   logic              w_addr_err;
   logic [DATA_W-1:0] w_ram_rdata;

   assign w_addr_err = {1'b0, paddr_i} >= DEPTH_L;
   assign w_commit   = (r_state == S_DONE) && r_write && !r_err;

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_state   <= S_IDLE;
         r_wait    <= '0;
         r_addr    <= '0;
         r_write   <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
      end else begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (psel_i && !penable_i) begin
                  r_state <= S_ACCESS;
                  r_wait  <= 4'(WAIT_STATES);
                  r_addr  <= paddr_i[AW-1:0];
                  r_write <= pwrite_i;
                  r_err   <= w_addr_err;
                  r_wdata <= pwdata_i;
               end
            end
            S_ACCESS: begin
               // master abandoned the transfer: drop it silently
               if (!psel_i) begin
                  r_state <= S_IDLE;
               end else if (r_wait != 4'd0) begin
                  r_wait <= r_wait - 4'd1;
               end else begin
                  r_state   <= S_DONE;
                  r_pready  <= 1'b1;
                  r_pslverr <= r_err;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_valid    <= '0;
         r_count    <= '0;
         r_ovw      <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_hit   <= 1'b0;
      end else begin
         r_rd_valid <= rd_en_i;
         if (rd_en_i) r_rd_hit <= r_valid[rd_addr_i];
         if (clr_i) begin
            r_valid <= '0;
            r_count <= '0;
            r_ovw   <= 1'b0;
         end else if (w_commit) begin
            r_valid[r_addr] <= 1'b1;
            r_count         <= r_count + CNT_W'(1);
            if (r_valid[r_addr]) r_ovw <= 1'b1;
         end
      end
   end

`ifdef SAMPLE_STORE_MINMAX_EN
   logic [DATA_W-1:0] r_min;
   logic [DATA_W-1:0] r_max;

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         r_min <= '1;
         r_max <= '0;
      end else if (clr_i) begin
         r_min <= '1;
         r_max <= '0;
      end else if (w_commit) begin
         if (r_wdata < r_min) r_min <= r_wdata;
         if (r_wdata > r_max) r_max <= r_wdata;
      end
   end

   assign min_o = r_min;
   assign max_o = r_max;
`else
   assign min_o = '0;
   assign max_o = '0;
`endif

   sample_store_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .i_clk     (pclk_i),
      .i_rst_n   (presetn_i),
      .i_we      (w_commit),
      .i_waddr   (r_addr),
      .i_wdata   (r_wdata),
      .i_raddr   (r_addr),
      .o_rdata   (w_ram_rdata),
      .i_rd_en   (rd_en_i),
      .i_rd_addr (rd_addr_i),
      .o_rd_data (rd_data_o)
   );

   assign prdata_o   = (r_state == S_DONE && !r_write && !r_err) ?
                       w_ram_rdata : '0;
   assign pready_o   = r_pready;
   assign pslverr_o  = r_pslverr;
   assign rd_valid_o = r_rd_valid;
   assign rd_hit_o   = r_rd_hit;
   assign wr_count_o = r_count;
   assign ovw_o      = r_ovw;

endmodule

// File: tb/tb_apb_sample_store.sv
// Randomized self-checking bench for apb_sample_store against a
// behavioural model (array memory, valid flags, counters).
module tb_apb_sample_store;

   localparam int DEPTH = 128;
   localparam int WS    = 1;
   localparam int CNT_W = 8;
`ifdef SAMPLE_STORE_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]  paddr = '0;
   logic [31:0] pwdata = '0;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic        clr = 1'b0, rd_en = 1'b0;
   logic [6:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        rd_valid, rd_hit;
   logic [7:0]  wr_count;
   logic        ovw;
   logic [31:0] min_v, max_v;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_mem   [256];
   bit          m_known [256];
   bit          m_valid [256];
   int          m_count;
   bit          m_ovw;
   logic [31:0] m_min, m_max;

   always #5 clk = ~clk;

   apb_sample_store #(
      .DEPTH(DEPTH), .WAIT_STATES(WS), .CNT_W(CNT_W)
   ) dut (
      .pclk_i(clk), .presetn_i(rst_n),
      .psel_i(psel), .penable_i(penable), .paddr_i(paddr),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata),
      .pready_o(pready), .pslverr_o(pslverr), .clr_i(clr),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .rd_valid_o(rd_valid), .rd_hit_o(rd_hit),
      .wr_count_o(wr_count), .ovw_o(ovw),
      .min_o(min_v), .max_o(max_v)
   );

   function automatic void m_clear();
      for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
      m_count = 0;
      m_ovw   = 1'b0;
      m_min   = 32'hFFFF_FFFF;
      m_max   = 32'h0;
   endfunction

   function automatic void m_commit(input int a, input logic [31:0] d);
      if (a >= DEPTH) return;
      if (m_valid[a]) m_ovw = 1'b1;
      m_mem[a]   = d;
      m_known[a] = 1'b1;
      m_valid[a] = 1'b1;
      m_count++;
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
   endfunction

   // All tasks start and end 1 time unit after a rising edge.
   task automatic apb_xfer(
      input  logic [7:0]  a, input logic w, input logic [31:0] d,
      input  bit side, input logic [6:0] sa, input bit clr_done,
      output logic [31:0] rdata, output logic err, output int lat,
      output logic [31:0] sdata, output logic shit, output logic svalid);
      bit seen = 1'b0;
      psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (pready === 1'b1) seen = 1'b1;
      end
      rdata = prdata;
      err   = pslverr;
      psel = 1'b0; penable = 1'b0;
      if (side) begin rd_en = 1'b1; rd_addr = sa; end
      if (clr_done) clr = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0; clr = 1'b0;
      sdata = rd_data; shit = rd_hit; svalid = rd_valid;
   endtask

   task automatic side_read(input logic [6:0] a, output logic [31:0] d,
                            output logic h, output logic v);
      rd_en = 1'b1; rd_addr = a;
      @(posedge clk); #1;
      rd_en = 1'b0;
      d = rd_data; h = rd_hit; v = rd_valid;
   endtask

   task automatic do_clear();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      m_clear();
   endtask

   task automatic test_reset();
      logic [31:0] emin;
      emin = MM ? 32'hFFFF_FFFF : 32'h0;
      m_clear();
      for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
      #12;
      total++;
      if ({pready, pslverr, rd_valid, rd_hit, ovw} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags got=%b want=00000",
                  {pready, pslverr, rd_valid, rd_hit, ovw});
      end
      total++;
      if ({prdata, rd_data, wr_count} !== '0) begin
         bad++;
         $display("FAIL reset_data prdata=%h rd_data=%h cnt=%0d want 0",
                  prdata, rd_data, wr_count);
      end
      total++;
      if (min_v !== emin || max_v !== 32'h0) begin
         bad++;
         $display("FAIL reset_minmax got=%h/%h want=%h/0",
                  min_v, max_v, emin);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_write();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd3, 1'b1, 32'hA5A5_0001, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(3, 32'hA5A5_0001);
      total++;
      if (lat !== WS + 1) begin
         bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, WS + 1);
      end
      total++;
      if (e !== 1'b0 || wr_count !== 8'(m_count)) begin
         bad++;
         $display("FAIL basic_status err=%b cnt=%0d want 0/%0d",
                  e, wr_count, m_count);
      end
      side_read(7'd3, sd, sh, sv);
      total++;
      if (sd !== 32'hA5A5_0001 || sh !== 1'b1 || sv !== 1'b1) begin
         bad++;
         $display("FAIL basic_side got=%h hit=%b v=%b want a5a50001/1/1",
                  sd, sh, sv);
      end
      @(posedge clk); #1;
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 32'hA5A5_0001) begin
         bad++;
         $display("FAIL side_hold v=%b d=%h want 0/a5a50001", rd_valid, rd_data);
      end
   endtask

   task automatic test_error();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd200, 1'b1, 32'hDEAD_BEEF, 0, '0, 0, rd, e, lat, sd, sh, sv);
      total++;
      if (e !== 1'b1 || lat !== WS + 1 || wr_count !== 8'(m_count)) begin
         bad++;
         $display("FAIL err_write err=%b lat=%0d cnt=%0d want 1/%0d/%0d",
                  e, lat, wr_count, WS + 1, m_count);
      end
      apb_xfer(8'd200, 1'b0, '0, 0, '0, 0, rd, e, lat, sd, sh, sv);
      total++;
      if (e !== 1'b1 || rd !== 32'h0) begin
         bad++;
         $display("FAIL err_read err=%b prdata=%h want 1/0", e, rd);
      end
   endtask

   task automatic test_overwrite();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd0, 1'b1, 32'h11, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(0, 32'h11);
      total++;
      if (ovw !== m_ovw) begin
         bad++; $display("FAIL ovw_first got=%b want=%b", ovw, m_ovw);
      end
      apb_xfer(8'd0, 1'b1, 32'h22, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(0, 32'h22);
      total++;
      if (ovw !== 1'b1) begin
         bad++; $display("FAIL ovw_second got=%b want=1", ovw);
      end
      apb_xfer(8'd0, 1'b0, '0, 0, '0, 0, rd, e, lat, sd, sh, sv);
      total++;
      if (rd !== 32'h22 || e !== 1'b0) begin
         bad++; $display("FAIL ovw_read got=%h err=%b want 22/0", rd, e);
      end
      do_clear();
      side_read(7'd0, sd, sh, sv);
      total++;
      if (ovw !== 1'b0 || wr_count !== 8'd0 || sh !== 1'b0 || sd !== 32'h22) begin
         bad++;
         $display("FAIL clr_state ovw=%b cnt=%0d hit=%b d=%h want 0/0/0/22",
                  ovw, wr_count, sh, sd);
      end
   endtask

   task automatic test_read_before_write();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd5, 1'b1, 32'h55, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(5, 32'h55);
      do_clear();
      apb_xfer(8'd5, 1'b1, 32'h77, 1, 7'd5, 0, rd, e, lat, sd, sh, sv);
      total++;
      if (sd !== 32'h55 || sh !== 1'b0 || sv !== 1'b1) begin
         bad++;
         $display("FAIL rbw_same got=%h hit=%b v=%b want 55/0/1", sd, sh, sv);
      end
      m_commit(5, 32'h77);
      side_read(7'd5, sd, sh, sv);
      total++;
      if (sd !== 32'h77 || sh !== 1'b1) begin
         bad++; $display("FAIL rbw_next got=%h hit=%b want 77/1", sd, sh);
      end
   endtask

   task automatic test_clr_commit();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd6, 1'b1, 32'h600D, 0, '0, 1, rd, e, lat, sd, sh, sv);
      m_commit(6, 32'h600D);
      m_clear();
      side_read(7'd6, sd, sh, sv);
      total++;
      if (wr_count !== 8'd0 || sh !== 1'b0 || sd !== 32'h600D) begin
         bad++;
         $display("FAIL clr_commit cnt=%0d hit=%b d=%h want 0/0/600d",
                  wr_count, sh, sd);
      end
   endtask

   task automatic test_protocol_abort();
      logic [31:0] sd; logic sh, sv; int seen;
      psel = 1'b1; penable = 1'b0; paddr = 8'd10; pwrite = 1'b1;
      pwdata = 32'h99;
      @(posedge clk); #1;
      penable = 1'b1; psel = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (pready === 1'b1) seen++;
      end
      penable = 1'b0;
      side_read(7'd10, sd, sh, sv);
      total++;
      if (seen !== 0 || wr_count !== 8'(m_count) || sh !== m_valid[10]) begin
         bad++;
         $display("FAIL abort pready_cnt=%0d cnt=%0d hit=%b want 0/%0d/%b",
                  seen, wr_count, sh, m_count, m_valid[10]);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] rd, sd, d; logic e, sh, sv; int lat;
      do_clear();
      for (int i = 0; i < 257; i++) begin
         d = $urandom;
         apb_xfer(8'd1, 1'b1, d, 0, '0, 0, rd, e, lat, sd, sh, sv);
         m_commit(1, d);
      end
      total++;
      if (wr_count !== 8'(m_count) || wr_count !== 8'd1 || ovw !== 1'b1) begin
         bad++;
         $display("FAIL wrap cnt=%0d ovw=%b want 1/1", wr_count, ovw);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, sd, d, esd, ep; logic e, sh, sv, eh, ee;
      int lat, op, a, sa;
      bit side, cl, ek;
      for (int it = 0; it < 120; it++) begin
         op   = $urandom_range(0, 9);
         a    = ($urandom_range(0, 7) == 0) ? $urandom_range(128, 255)
                                            : $urandom_range(0, 15);
         sa   = $urandom_range(0, 15);
         side = $urandom_range(0, 1);
         cl   = ($urandom_range(0, 7) == 0);
         d    = $urandom;
         esd  = m_mem[sa]; ek = m_known[sa]; eh = m_valid[sa];
         if (op <= 6) begin
            apb_xfer(8'(a), op <= 4, d, side, 7'(sa), cl,
                     rd, e, lat, sd, sh, sv);
            ee = (a >= DEPTH);
            ep = (ee || op <= 4 || !m_known[a]) ? 32'h0 : m_mem[a];
            total++;
            if (lat !== WS + 1 || e !== ee || pready !== 1'b0 ||
                ((op > 4 && (ee || m_known[a])) && rd !== ep)) begin
               bad++;
               $display("FAIL rnd_apb it=%0d a=%0d lat=%0d err=%b rd=%h want %0d/%b/%h",
                        it, a, lat, e, rd, WS + 1, ee, ep);
            end
            if (op <= 4) m_commit(a, d);
            if (cl) m_clear();
         end else if (op <= 8) begin
            side = 1'b1;
            side_read(7'(sa), sd, sh, sv);
         end else begin
            side = 1'b0;
            do_clear();
         end
         if (side) begin
            total++;
            if (sv !== 1'b1 || sh !== eh || (ek && sd !== esd)) begin
               bad++;
               $display("FAIL rnd_side it=%0d a=%0d d=%h hit=%b want %h/%b",
                        it, sa, sd, sh, esd, eh);
            end
         end
         total++;
         if (wr_count !== 8'(m_count) || ovw !== m_ovw ||
             min_v !== (MM ? m_min : 32'h0) ||
             max_v !== (MM ? m_max : 32'h0)) begin
            bad++;
            $display("FAIL rnd_status it=%0d cnt=%0d ovw=%b min=%h max=%h",
                     it, wr_count, ovw, min_v, max_v);
         end
      end
   endtask

   task automatic test_minmax();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      do_clear();
      apb_xfer(8'd20, 1'b1, 32'd50, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(20, 32'd50);
      apb_xfer(8'd21, 1'b1, 32'd7, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(21, 32'd7);
      apb_xfer(8'd22, 1'b1, 32'd300, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(22, 32'd300);
      total++;
      if (min_v !== (MM ? 32'd7 : 32'd0) || max_v !== (MM ? 32'd300 : 32'd0)) begin
         bad++; $display("FAIL minmax min=%0d max=%0d", min_v, max_v);
      end
      do_clear();
      total++;
      if (min_v !== (MM ? 32'hFFFF_FFFF : 32'h0) || max_v !== 32'h0) begin
         bad++; $display("FAIL minmax_clr min=%h max=%h", min_v, max_v);
      end
   endtask

   task automatic test_reset_access();
      logic [31:0] rd, sd; logic e, sh, sv; int lat;
      apb_xfer(8'd9, 1'b1, 32'h9, 0, '0, 0, rd, e, lat, sd, sh, sv);
      m_commit(9, 32'h9);
      psel = 1'b1; penable = 1'b0; paddr = 8'd9; pwrite = 1'b1;
      pwdata = 32'h999;
      @(posedge clk); #1;
      penable = 1'b1;
      rst_n = 1'b0;
      #1;
      total++;
      if (pready !== 1'b0 || pslverr !== 1'b0) begin
         bad++;
         $display("FAIL rst_access pready=%b pslverr=%b want 0/0", pready, pslverr);
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_clear();
      @(posedge clk); #1;
      side_read(7'd9, sd, sh, sv);
      total++;
      if (sh !== 1'b0 || wr_count !== 8'd0 || ovw !== 1'b0) begin
         bad++;
         $display("FAIL rst_after hit=%b cnt=%0d ovw=%b want 0/0/0",
                  sh, wr_count, ovw);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_error();
      test_overwrite();
      test_read_before_write();
      test_clr_commit();
      test_protocol_abort();
      test_wrap();
      test_random();
      test_minmax();
      test_reset_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
